// File: rtl/uart_tx_fifo_if.sv
// Core-side write port of the UART transmitter: byte enqueue, FIFO status
// and the sticky overrun flag.
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       din;
    logic             wr;
    logic             clr_ovr;
    logic             full;
    logic             empty;
    logic [FIFO_AW:0] level;
    logic             busy;
    logic             overrun;

    modport master (
        output din, wr, clr_ovr,
        input  full, empty, level, busy, overrun
    );

    modport slave (
        input  din, wr, clr_ovr,
        output full, empty, level, busy, overrun
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter for UART_TX: byte FIFO feeding an
// LSB-first shifter with a registered, idle-high line output.
module uart_tx_fifo #(
    parameter int DIV     = 729,
    parameter int FIFO_AW = 4
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    uart_tx_fifo_if.slave bus,
    output logic         tx
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0]      BAUD_MAX = 16'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] level;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overrun;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_end;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == DEPTH);
    assign empty    = (level == '0);
    assign push     = bus.wr && !full;
    assign baud_end = (baud_q == BAUD_MAX);

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= bus.din;
        end
    end

    // Set beats clear so a drop coinciding with clr_ovr is never lost.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.wr && full) begin
                overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr[FIFO_AW-1:0]];
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from next state so tx leaves a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx          = tx_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.level   = level;
    assign bus.busy    = (state_q != IDLE);
    assign bus.overrun = overrun;
endmodule
